rgmii_tx: RTL and testbench

RGMII_TX -- requirements
Module: rgmii_tx

---
 rtl/rgmii_tx_if.sv | 19 +
 rtl/rgmii_tx.sv | 86 ++++++++
 tb/tb_rgmii_tx.sv | 85 ++++++++
 3 files changed

// File: rtl/rgmii_tx_if.sv
// rgmii_tx_if: MAC byte handshake plus PHY-side DDR nibble/control outputs of rgmii_tx.
interface rgmii_tx_if;
  logic [7:0] rgmii_mac_tx_data;
  logic       rgmii_mac_tx_dv;
  logic       rgmii_mac_tx_er;
  logic       rgmii_mac_tx_rdy;
  logic [3:0] txd_rise;
  logic [3:0] txd_fall;
  logic       tx_ctl_rise;
  logic       tx_ctl_fall;
  modport master (
    output rgmii_mac_tx_data, rgmii_mac_tx_dv, rgmii_mac_tx_er,
    input  rgmii_mac_tx_rdy, txd_rise, txd_fall, tx_ctl_rise, tx_ctl_fall
  );
  modport slave (
    input  rgmii_mac_tx_data, rgmii_mac_tx_dv, rgmii_mac_tx_er,
    output rgmii_mac_tx_rdy, txd_rise, txd_fall, tx_ctl_rise, tx_ctl_fall
  );
endinterface

// File: rtl/rgmii_tx.sv
// rgmii_tx: MAC byte stream to RGMII DDR nibbles (gigabit) or MII nibble pairs (10/100).
// Define RGMII_TX_ER_EN to encode tx_er on the falling TX_CTL half (dv^er).
module rgmii_tx (
  input  logic    clk,
  input  logic    reset_n,
  input  logic    mii_select,
  rgmii_tx_if.slave bus
);
  typedef enum logic {LO, HI} state_t;
  state_t     state_q, state_d;
  logic       mode_q, mode_d;
  logic       rdy_q, rdy_d;
  logic [3:0] nib_q, nib_d;
  logic       er_q, er_d;
  logic [3:0] rise_q, rise_d, fall_q, fall_d;
  logic       ctl_r_q, ctl_r_d, ctl_f_q, ctl_f_d;
  logic       xfer;
  logic       er_in;
`ifdef RGMII_TX_ER_EN
  assign er_in = bus.rgmii_mac_tx_er;
`else
  assign er_in = 1'b0;
`endif
  always_comb begin
    xfer    = rdy_q & bus.rgmii_mac_tx_dv;
    // mode only follows mii_select between frames, so a frame never changes format
    mode_d  = (state_q == LO && !xfer) ? mii_select : mode_q;
    state_d = LO;
    nib_d   = nib_q;
    er_d    = er_q;
    rise_d  = 4'h0;
    fall_d  = 4'h0;
    ctl_r_d = 1'b0;
    ctl_f_d = 1'b0;
    if (!mode_q) begin
      if (xfer) begin
        rise_d  = bus.rgmii_mac_tx_data[3:0];
        fall_d  = bus.rgmii_mac_tx_data[7:4];
        ctl_r_d = 1'b1;
        ctl_f_d = 1'b1 ^ er_in;
      end
    end else if (state_q == HI) begin
      rise_d  = nib_q;
      fall_d  = nib_q;
      ctl_r_d = 1'b1;
      ctl_f_d = 1'b1 ^ er_q;
    end else if (xfer) begin
      rise_d  = bus.rgmii_mac_tx_data[3:0];
      fall_d  = bus.rgmii_mac_tx_data[3:0];
      ctl_r_d = 1'b1;
      ctl_f_d = 1'b1 ^ er_in;
      nib_d   = bus.rgmii_mac_tx_data[7:4];
      er_d    = er_in;
      state_d = HI;
    end
    rdy_d = !mode_d || state_d == LO;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= LO;
      mode_q  <= 1'b0;
      rdy_q   <= 1'b0;
      nib_q   <= 4'h0;
      er_q    <= 1'b0;
      rise_q  <= 4'h0;
      fall_q  <= 4'h0;
      ctl_r_q <= 1'b0;
      ctl_f_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rdy_q   <= rdy_d;
      nib_q   <= nib_d;
      er_q    <= er_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      ctl_r_q <= ctl_r_d;
      ctl_f_q <= ctl_f_d;
    end
  end
  assign bus.rgmii_mac_tx_rdy = rdy_q;
  assign bus.txd_rise         = rise_q;
  assign bus.txd_fall         = fall_q;
  assign bus.tx_ctl_rise      = ctl_r_q;
  assign bus.tx_ctl_fall      = ctl_f_q;
endmodule

// File: tb/tb_rgmii_tx.sv
// tb_rgmii_tx: directed checks of rgmii_tx in gigabit and MII modes, error encoding, mode change and reset abort.
module tb_rgmii_tx;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic mii_select = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  rgmii_tx_if b ();
  rgmii_tx dut (.clk(clk), .reset_n(reset_n), .mii_select(mii_select), .bus(b.slave));
  always #5 clk = ~clk;
`ifdef RGMII_TX_ER_EN
  localparam logic ERF = 1'b0;
`else
  localparam logic ERF = 1'b1;
`endif
  function automatic logic [10:0] e(logic r, logic [3:0] a, logic [3:0] f, logic c, logic d);
    return {r, a, f, c, d};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string tag, logic [10:0] exp);
    logic [10:0] got;
    got = {b.rgmii_mac_tx_rdy, b.txd_rise, b.txd_fall, b.tx_ctl_rise, b.tx_ctl_fall};
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got={rdy,rise,fall,cr,cf}=%h required=%h", tag, got, exp);
    end
  endtask
  task automatic drv(logic [7:0] d, logic dv, logic er);
    b.rgmii_mac_tx_data = d;
    b.rgmii_mac_tx_dv   = dv;
    b.rgmii_mac_tx_er   = er;
  endtask
  initial begin
    drv(8'h00, 1'b0, 1'b0);
    tick(); tick();
    chk("reset", e(0, 4'h0, 4'h0, 0, 0));
    reset_n = 1'b1;
    tick();
    chk("release", e(1, 4'h0, 4'h0, 0, 0));
    drv(8'hA5, 1'b1, 1'b0); tick(); chk("gig_a5", e(1, 4'h5, 4'hA, 1, 1));
    drv(8'h3C, 1'b1, 1'b0); tick(); chk("gig_3c", e(1, 4'hC, 4'h3, 1, 1));
    drv(8'h3C, 1'b0, 1'b0); tick(); chk("gig_end", e(1, 4'h0, 4'h0, 0, 0));
    drv(8'hFF, 1'b0, 1'b1); tick(); chk("gig_er_nodv", e(1, 4'h0, 4'h0, 0, 0));
    drv(8'h55, 1'b1, 1'b1); tick(); chk("gig_err", e(1, 4'h5, 4'h5, 1, ERF));
    drv(8'h00, 1'b0, 1'b0); tick(); chk("gig_err_end", e(1, 4'h0, 4'h0, 0, 0));
    mii_select = 1'b1;
    tick(); chk("mii_idle", e(1, 4'h0, 4'h0, 0, 0));
    drv(8'hA5, 1'b1, 1'b0); tick(); chk("mii_a5_lo", e(0, 4'h5, 4'h5, 1, 1));
    drv(8'hEE, 1'b1, 1'b1); tick(); chk("mii_a5_hi", e(1, 4'hA, 4'hA, 1, 1));
    drv(8'h3C, 1'b1, 1'b0); tick(); chk("mii_3c_lo", e(0, 4'hC, 4'hC, 1, 1));
    drv(8'h00, 1'b0, 1'b0); tick(); chk("mii_3c_hi", e(1, 4'h3, 4'h3, 1, 1));
    tick(); chk("mii_end", e(1, 4'h0, 4'h0, 0, 0));
    drv(8'h81, 1'b1, 1'b0); tick(); chk("mii_81_lo", e(0, 4'h1, 4'h1, 1, 1));
    drv(8'h00, 1'b0, 1'b0); tick(); chk("mii_81_hi", e(1, 4'h8, 4'h8, 1, 1));
    tick(); chk("mii_81_end", e(1, 4'h0, 4'h0, 0, 0));
    mii_select = 1'b0;
    tick(); chk("to_gig", e(1, 4'h0, 4'h0, 0, 0));
    drv(8'h11, 1'b1, 1'b0); tick(); chk("mc_b1", e(1, 4'h1, 4'h1, 1, 1));
    drv(8'h22, 1'b1, 1'b0); tick(); chk("mc_b2", e(1, 4'h2, 4'h2, 1, 1));
    mii_select = 1'b1;
    drv(8'h43, 1'b1, 1'b0); tick(); chk("mc_b3", e(1, 4'h3, 4'h4, 1, 1));
    drv(8'h74, 1'b1, 1'b0); tick(); chk("mc_b4", e(1, 4'h4, 4'h7, 1, 1));
    drv(8'h00, 1'b0, 1'b0); tick(); chk("mc_end", e(1, 4'h0, 4'h0, 0, 0));
    drv(8'h96, 1'b1, 1'b0); tick(); chk("mc_mii_lo", e(0, 4'h6, 4'h6, 1, 1));
    drv(8'h00, 1'b0, 1'b0); tick(); chk("mc_mii_hi", e(1, 4'h9, 4'h9, 1, 1));
    tick(); chk("mc_mii_end", e(1, 4'h0, 4'h0, 0, 0));
    drv(8'hF0, 1'b1, 1'b0); tick(); chk("rst_f0_lo", e(0, 4'h0, 4'h0, 1, 1));
    drv(8'h00, 1'b0, 1'b0);
    #1 reset_n = 1'b0;
    #1 chk("rst_async", e(0, 4'h0, 4'h0, 0, 0));
    tick(); chk("rst_held", e(0, 4'h0, 4'h0, 0, 0));
    reset_n = 1'b1;
    tick(); chk("rst_rel", e(1, 4'h0, 4'h0, 0, 0));
    tick(); chk("rst_no_f", e(1, 4'h0, 4'h0, 0, 0));
    drv(8'h5A, 1'b1, 1'b0); tick(); chk("post_rst_lo", e(0, 4'hA, 4'hA, 1, 1));
    drv(8'h00, 1'b0, 1'b0); tick(); chk("post_rst_hi", e(1, 4'h5, 4'h5, 1, 1));
    tick(); chk("post_rst_end", e(1, 4'h0, 4'h0, 0, 0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
